ex_job_scheduler: RTL and testbench

//  Upstream feeder for the a*3 + 2*cbrt(b) compute unit. Buffers operand pairs
//  in a FIFO and launches one job at a time on the unit's start/busy interface.

---
 rtl/ex_job_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_ex_job_scheduler.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_job_scheduler.sv
// ex_job_scheduler
//   Upstream feeder for the a*3 + 2*cbrt(b) compute unit. Operand pairs are
//   buffered in a small FIFO and launched one at a time on the unit's
//   start/busy handshake. start_o stays high for the whole job because the
//   unit resets whenever start is low. Each result is captured, tagged with a
//   wrapping sequence number and offered on a valid/ready output.
//
//   Optional feature macro: EX_SCHED_TIMEOUT_EN
//     defined   - watchdog aborts a job stuck in ARM/RUN after TIMEOUT_CYC
//                 cycles and emits an all-ones result with err_o=1
//     undefined - no watchdog, err_o tied to 0
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-low reset
//   in_valid_i   operand pair valid
//   in_ready_o   FIFO can accept a pair
//   in_a_i       operand a
//   in_b_i       operand b
//   start_o      unit start, held from launch until capture
//   a_o, b_o     unit operands, stable while start_o=1
//   busy_i       unit busy
//   res_i        unit result
//   res_valid_o  result register full
//   res_ready_i  consumer accepts result
//   res_o        captured result
//   res_tag_o    sequence tag of res_o
//   err_o        result is a timeout marker
module ex_job_scheduler #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 4,
    parameter int TAG_W       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_a_i,
    input  logic [DATA_W-1:0] in_b_i,
    output logic              start_o,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    input  logic              busy_i,
    input  logic [DATA_W-1:0] res_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [DATA_W-1:0] res_o,
    output logic [TAG_W-1:0]  res_tag_o,
    output logic              err_o
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARM  = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] GAP  = 2'd3;

    logic [1:0]        state;
    logic [DATA_W-1:0] fifo_a [DEPTH];
    logic [DATA_W-1:0] fifo_b [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [TAG_W-1:0]  tag;
    logic              push;
    logic              pop;

    // Readiness depends only on the registered count, so a pop in the same
    // cycle never unblocks a push into a full FIFO.
    assign in_ready_o = (count != FULL_CNT);
    assign push       = in_valid_i & in_ready_o;
    // Launch only into an empty result register so capture never stalls.
    assign pop        = (state == IDLE) & (count != '0) & ~res_valid_o;

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_a[wr_ptr] <= in_a_i;
            fifo_b[wr_ptr] <= in_b_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef EX_SCHED_TIMEOUT_EN
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYC - 1);

    logic [31:0] wd_cnt;
    logic        err_q;
    logic        timeout;

    assign timeout = ((state == ARM) || (state == RUN)) && (wd_cnt == WD_LAST);
    assign err_o   = err_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wd_cnt <= '0;
        end else if (pop) begin
            wd_cnt <= '0;
        end else if ((state == ARM) || (state == RUN)) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            start_o     <= 1'b0;
            a_o         <= '0;
            b_o         <= '0;
            res_valid_o <= 1'b0;
            res_o       <= '0;
            res_tag_o   <= '0;
            tag         <= '0;
`ifdef EX_SCHED_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
        end else begin
            if (res_valid_o && res_ready_i) res_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        a_o     <= fifo_a[rd_ptr];
                        b_o     <= fifo_b[rd_ptr];
                        start_o <= 1'b1;
                        state   <= ARM;
                    end
                end
                ARM: begin
`ifdef EX_SCHED_TIMEOUT_EN
                    if (timeout) begin
                        start_o     <= 1'b0;
                        res_o       <= '1;
                        err_q       <= 1'b1;
                        res_valid_o <= 1'b1;
                        res_tag_o   <= tag;
                        tag         <= tag + 1'b1;
                        state       <= GAP;
                    end else
`endif
                    // A low busy_i here is left over from before the unit saw
                    // start, so only a rising busy moves the job on.
                    if (busy_i) state <= RUN;
                end
                RUN: begin
                    if (!busy_i) begin
                        start_o     <= 1'b0;
                        res_o       <= res_i;
                        res_valid_o <= 1'b1;
                        res_tag_o   <= tag;
                        tag         <= tag + 1'b1;
                        state       <= GAP;
`ifdef EX_SCHED_TIMEOUT_EN
                        err_q       <= 1'b0;
`endif
                    end
`ifdef EX_SCHED_TIMEOUT_EN
                    else if (timeout) begin
                        start_o     <= 1'b0;
                        res_o       <= '1;
                        err_q       <= 1'b1;
                        res_valid_o <= 1'b1;
                        res_tag_o   <= tag;
                        tag         <= tag + 1'b1;
                        state       <= GAP;
                    end
`endif
                end
                default: begin
                    // GAP: one cycle with start low so the unit resets.
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_job_scheduler.sv
// tb_ex_job_scheduler
//   Scoreboard bench for ex_job_scheduler. A behavioural compute unit answers
//   the start/busy handshake with random latencies. Accepted pushes queue the
//   expected launch operands and tagged results; a monitor pops and compares
//   whenever a launch or a result handshake is observed.
module tb_ex_job_scheduler;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int TW    = 4;

    logic          clk_i       = 1'b0;
    logic          rst_i       = 1'b0;
    logic          in_valid_i  = 1'b0;
    logic [DW-1:0] in_a_i      = '0;
    logic [DW-1:0] in_b_i      = '0;
    logic          busy_i      = 1'b0;
    logic [DW-1:0] res_i       = '0;
    logic          res_ready_i = 1'b0;
    logic          in_ready_o;
    logic          start_o;
    logic [DW-1:0] a_o;
    logic [DW-1:0] b_o;
    logic          res_valid_o;
    logic [DW-1:0] res_o;
    logic [TW-1:0] res_tag_o;
    logic          err_o;

    always #5 clk_i = ~clk_i;

    ex_job_scheduler #(
        .DATA_W      (DW),
        .DEPTH       (DEPTH),
        .TAG_W       (TW),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_a_i      (in_a_i),
        .in_b_i      (in_b_i),
        .start_o     (start_o),
        .a_o         (a_o),
        .b_o         (b_o),
        .busy_i      (busy_i),
        .res_i       (res_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_o       (res_o),
        .res_tag_o   (res_tag_o),
        .err_o       (err_o)
    );

    typedef struct {
        logic [DW-1:0] res;
        logic [TW-1:0] tag;
        logic          err;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] la_q[$];
    logic [DW-1:0] lb_q[$];
    int            n_checks  = 0;
    int            n_fail    = 0;
    int            acc       = 0;
    int            launches  = 0;
    int            model_tag = 0;
    bit            stuck     = 0;
    int            unit_min  = 1;
    int            unit_max  = 4;
    bit            rnd_done  = 0;

    // a*3 + 2*floor(cbrt(b)), modulo 2^DW
    function automatic logic [DW-1:0] ref_fn(input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint unsigned r = 0;
        longint unsigned bb = 64'(b);
        while ((r + 1) * (r + 1) * (r + 1) <= bb) r++;
        return DW'(64'(a) * 3 + 2 * r);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b);
        bit   ok = 0;
        int   w  = 0;
        exp_t e;
        in_valid_i = 1'b1;
        in_a_i     = a;
        in_b_i     = b;
        while (!ok) begin
            @(negedge clk_i);
            ok = in_ready_o;
            @(posedge clk_i);
            if (ok) begin
                e.res = stuck ? '1 : ref_fn(a, b);
                e.tag = TW'(model_tag);
                e.err = stuck;
                exp_q.push_back(e);
                la_q.push_back(a);
                lb_q.push_back(b);
                acc++;
                model_tag++;
            end
            #1;
            w++;
            if (!ok && w > 300) begin
                fail_now("push_wait");
                ok = 1;
            end
        end
        in_valid_i = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic wait_res_valid(input int budget);
        int w = 0;
        while (!res_valid_o && w < budget) begin
            tick(1);
            w++;
        end
        if (!res_valid_o) fail_now("res_valid_wait");
    endtask

    task automatic wait_drain(input int budget);
        int w = 0;
        while ((exp_q.size() != 0 || res_valid_o || launches != acc) && w < budget) begin
            tick(1);
            w++;
        end
        if (exp_q.size() != 0 || res_valid_o || launches != acc) fail_now("drain");
    endtask

    // Behavioural compute unit: resets while start is low, raises busy after
    // a random delay, drops it with the result after a random work time.
    initial begin
        int phase = 0;
        int cnt   = 0;
        forever begin
            @(posedge clk_i);
            #1;
            if (!start_o) begin
                busy_i = 1'b0;
                phase  = 0;
            end else begin
                case (phase)
                    0: begin
                        cnt    = $urandom_range(unit_max, unit_min);
                        busy_i = 1'b0;
                        phase  = 1;
                    end
                    1: begin
                        if (cnt > 0) cnt--;
                        else begin
                            busy_i = 1'b1;
                            cnt    = $urandom_range(unit_max, unit_min);
                            phase  = 2;
                        end
                    end
                    2: begin
                        res_i = $urandom;
                        if (!stuck) begin
                            if (cnt > 0) cnt--;
                            else begin
                                res_i  = ref_fn(a_o, b_o);
                                busy_i = 1'b0;
                                phase  = 3;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Monitor: launches, start gap, FIFO occupancy and result handshakes.
    bit            prev_start = 0;
    bit            gap_chk    = 0;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    exp_t          er;
    always @(negedge clk_i) begin
        if (rst_i) begin
            if (gap_chk) check("start_gap", 64'(start_o), 64'd0);
            gap_chk = prev_start && !start_o;
            if (start_o && !prev_start) begin
                if (la_q.size() == 0) begin
                    fail_now("launch_unexpected");
                end else begin
                    ea = la_q.pop_front();
                    eb = lb_q.pop_front();
                    check("launch_a", 64'(a_o), 64'(ea));
                    check("launch_b", 64'(b_o), 64'(eb));
                end
                launches++;
            end
            check("in_ready", 64'(in_ready_o), 64'((acc - launches) < DEPTH));
            if (res_valid_o && res_ready_i) begin
                if (exp_q.size() == 0) begin
                    fail_now("result_unexpected");
                end else begin
                    er = exp_q.pop_front();
                    check("res", 64'(res_o), 64'(er.res));
                    check("res_tag", 64'(res_tag_o), 64'(er.tag));
                    check("err", 64'(err_o), 64'(er.err));
                end
            end
        end else begin
            gap_chk = 0;
        end
        prev_start = start_o;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        // Reset state
        rst_i = 1'b0;
        tick(2);
        check("rst_start", 64'(start_o), 64'd0);
        check("rst_res_valid", 64'(res_valid_o), 64'd0);
        check("rst_in_ready", 64'(in_ready_o), 64'd1);
        check("rst_res", 64'(res_o), 64'd0);
        check("rst_tag", 64'(res_tag_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_a", 64'(a_o), 64'd0);
        rst_i = 1'b1;
        tick(1);

        // Single job
        res_ready_i = 1'b1;
        push(32'd5, 32'd27);
        wait_drain(200);

        // Back-to-back jobs
        push(32'd2, 32'd8);
        push(32'd1, 32'd1);
        push(32'd0, 32'd0);
        push(32'd3, 32'd64);
        wait_drain(400);

        // Backpressure: one held result, four queued
        res_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) push(DW'(i + 10), DW'(i * 7));
        wait_res_valid(200);
        for (int i = 0; i < 10; i++) begin
            check("held_no_start", 64'(start_o), 64'd0);
            tick(1);
        end
        check("held_full", 64'(in_ready_o), 64'd0);
        check("held_valid", 64'(res_valid_o), 64'd1);
        res_ready_i = 1'b1;
        push(32'd15, 32'd35);
        wait_drain(600);

        // Simultaneous push and pop at count DEPTH-1
        res_ready_i = 1'b0;
        push(32'd20, 32'd125);
        wait_res_valid(200);
        tick(3);
        push(32'd21, 32'd2);
        push(32'd22, 32'd3);
        push(32'd23, 32'd4);
        res_ready_i = 1'b1;
        tick(1);
        res_ready_i = 1'b0;
        push(32'd24, 32'd1000);
        check("pushpop_ready", 64'(in_ready_o), 64'd1);
        check("pushpop_launch", 64'(start_o), 64'd1);
        res_ready_i = 1'b1;
        wait_drain(600);

        // Random traffic with random consumer backpressure; tags wrap
        rnd_done = 0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    push($urandom, $urandom);
                    tick($urandom_range(3, 0));
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    res_ready_i = 1'($urandom_range(1, 0));
                    tick(1);
                end
            end
        join
        res_ready_i = 1'b1;
        wait_drain(2000);

        // Reset while RUN with jobs queued
        unit_min = 4;
        unit_max = 5;
        push(32'd7, 32'd8);
        push(32'd8, 32'd9);
        push(32'd9, 32'd10);
        begin
            int w = 0;
            while (!(start_o && busy_i) && w < 100) begin
                tick(1);
                w++;
            end
            if (!(start_o && busy_i)) fail_now("run_wait");
        end
        tick(1);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        exp_q.delete();
        la_q.delete();
        lb_q.delete();
        acc       = 0;
        launches  = 0;
        model_tag = 0;
        check("mid_rst_start", 64'(start_o), 64'd0);
        check("mid_rst_valid", 64'(res_valid_o), 64'd0);
        check("mid_rst_empty", 64'(in_ready_o), 64'd1);
        rst_i    = 1'b1;
        unit_min = 1;
        unit_max = 4;
        tick(1);
        push(32'd5, 32'd27);
        wait_drain(200);

`ifdef EX_SCHED_TIMEOUT_EN
        // Unit stuck busy: watchdog aborts the job
        stuck = 1;
        push(32'd9, 32'd1);
        begin
            int n = 0;
            while (!start_o && n < 100) begin
                @(negedge clk_i);
                n++;
            end
            n = 0;
            while (start_o && n < 100) begin
                n++;
                @(negedge clk_i);
            end
            check("timeout_cycles", 64'(n), 64'd16);
        end
        @(posedge clk_i);
        #1;
        stuck = 0;
        wait_drain(200);
        push(32'd2, 32'd8);
        wait_drain(200);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
